// File: rtl/mp_cache_tag_pkg.sv
// Shared constants and types for the cache tag SRAM controller.
package mp_cache_tag_pkg;

    localparam int unsigned SET_BITS   = 5;
    localparam int unsigned TAG_WIDTH  = 21;
    localparam int unsigned WORD_WIDTH = 23;

    // Layout of one tag SRAM word, MSB first.
    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAG_WIDTH-1:0] tag;
    } tag_word_t;

    // Fixed state encodings so older code that compares raw values keeps working.
    localparam logic [1:0] ST_RST   = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_IDLE  = 2'd2;

    typedef enum logic [1:0] {
        RST   = ST_RST,
        SWEEP = ST_SWEEP,
        IDLE  = ST_IDLE
    } ctrl_state_t;

endpackage

// File: rtl/mp_cache_tag_sweep.sv
// Set counter that walks every SRAM set once; shared by init clear and flush.
module mp_cache_tag_sweep
    import mp_cache_tag_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                en_i,
    output logic [SET_BITS-1:0] cnt_o,
    output logic                last_o,
    output logic                done_o
);

    logic [SET_BITS-1:0] cnt_q, cnt_d;
    logic                done_q, done_d;

    // Advance one set per enabled cycle and wrap to 0 after the final set.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d  = last_o ? '0 : cnt_q + SET_BITS'(1);
            done_d = last_o;
        end
    end

    // Counter state; done is a one-cycle pulse the cycle after the last set is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = &cnt_q;
    assign done_o = done_q;

endmodule

// File: rtl/mp_cache_tag_ctrl.sv
// Tag SRAM sequencer: clears the SRAM after reset, then arbitrates its single
// RW port between flush sweeps, tag updates and lookups.
module mp_cache_tag_ctrl
    import mp_cache_tag_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_done,
    input  logic                  lk_valid,
    output logic                  lk_ready,
    input  logic [SET_BITS-1:0]   lk_set,
    input  logic [TAG_WIDTH-1:0]  lk_tag,
    output logic                  rsp_valid,
    output logic                  rsp_hit,
    output logic                  rsp_dirty,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [SET_BITS-1:0]   upd_set,
    input  logic [WORD_WIDTH-1:0] upd_word,
    input  logic                  flush_req,
    output logic                  flush_done,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic [SET_BITS-1:0]   sram_addr,
    output logic [WORD_WIDTH-1:0] sram_din,
    input  logic [WORD_WIDTH-1:0] sram_dout
);

    ctrl_state_t          state_q, state_d;
    logic                 is_flush_q, is_flush_d;
    logic                 init_done_q, init_done_d;
    logic                 pend_q, pend_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;

    logic                 sweep_start;
    logic                 sweep_en;
    logic                 sweep_last;
    logic                 sweep_done;
    logic [SET_BITS-1:0]  sweep_cnt;
    tag_word_t            rd_word;

    mp_cache_tag_sweep u_sweep (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (sweep_start),
        .en_i    (sweep_en),
        .cnt_o   (sweep_cnt),
        .last_o  (sweep_last),
        .done_o  (sweep_done)
    );

    // Next-state and SRAM port arbitration: flush > update > lookup.
    always_comb begin
        state_d     = state_q;
        is_flush_d  = is_flush_q;
        init_done_d = init_done_q;
        pend_d      = 1'b0;
        tag_d       = tag_q;
        sweep_start = 1'b0;
        sweep_en    = 1'b0;
        lk_ready    = 1'b0;
        upd_ready   = 1'b0;
        sram_csb    = 1'b1;
        sram_web    = 1'b1;
        sram_addr   = '0;
        sram_din    = '0;
        case (state_q)
            RST: begin
                state_d     = SWEEP;
                is_flush_d  = 1'b0;
                sweep_start = 1'b1;
            end
            SWEEP: begin
                sram_csb  = 1'b0;
                sram_web  = 1'b0;
                sram_addr = sweep_cnt;
                sweep_en  = 1'b1;
                if (sweep_last) begin
                    state_d = IDLE;
                    if (!is_flush_q) begin
                        init_done_d = 1'b1;
                    end
                end
            end
            IDLE: begin
                upd_ready = !flush_req;
                lk_ready  = !flush_req && !upd_valid;
                if (flush_req) begin
                    state_d     = SWEEP;
                    is_flush_d  = 1'b1;
                    sweep_start = 1'b1;
                end else if (upd_valid) begin
                    sram_csb  = 1'b0;
                    sram_web  = 1'b0;
                    sram_addr = upd_set;
                    sram_din  = upd_word;
                end else if (lk_valid) begin
                    sram_csb  = 1'b0;
                    sram_addr = lk_set;
                    tag_d     = lk_tag;
                    pend_d    = 1'b1;
                end
            end
            default: begin
                state_d = RST;
            end
        endcase
    end

    // Controller state; reset discards any pending lookup response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST;
            is_flush_q  <= 1'b0;
            init_done_q <= 1'b0;
            pend_q      <= 1'b0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            is_flush_q  <= is_flush_d;
            init_done_q <= init_done_d;
            pend_q      <= pend_d;
            tag_q       <= tag_d;
        end
    end

    assign rd_word = tag_word_t'(sram_dout);

    // Lookup result decode; all fields forced to 0 outside the response cycle.
    always_comb begin
        rsp_valid = pend_q;
        rsp_hit   = pend_q & rd_word.valid & (rd_word.tag == tag_q);
        rsp_dirty = pend_q & rd_word.valid & rd_word.dirty;
        rsp_tag   = pend_q ? rd_word.tag : '0;
    end

    assign init_done  = init_done_q;
    assign flush_done = sweep_done & is_flush_q;

endmodule

// File: tb/tb_mp_cache_tag_ctrl.sv
// Scoreboard bench for mp_cache_tag_ctrl with a behavioural single-port SRAM.
module tb_mp_cache_tag_ctrl;
    import mp_cache_tag_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  init_done;
    logic                  lk_valid = 1'b0;
    logic                  lk_ready;
    logic [SET_BITS-1:0]   lk_set = '0;
    logic [TAG_WIDTH-1:0]  lk_tag = '0;
    logic                  rsp_valid, rsp_hit, rsp_dirty;
    logic [TAG_WIDTH-1:0]  rsp_tag;
    logic                  upd_valid = 1'b0;
    logic                  upd_ready;
    logic [SET_BITS-1:0]   upd_set = '0;
    logic [WORD_WIDTH-1:0] upd_word = '0;
    logic                  flush_req = 1'b0;
    logic                  flush_done;
    logic                  sram_csb, sram_web;
    logic [SET_BITS-1:0]   sram_addr;
    logic [WORD_WIDTH-1:0] sram_din, sram_dout;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mp_cache_tag_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_done  (init_done),
        .lk_valid   (lk_valid),
        .lk_ready   (lk_ready),
        .lk_set     (lk_set),
        .lk_tag     (lk_tag),
        .rsp_valid  (rsp_valid),
        .rsp_hit    (rsp_hit),
        .rsp_dirty  (rsp_dirty),
        .rsp_tag    (rsp_tag),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_set    (upd_set),
        .upd_word   (upd_word),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .sram_csb   (sram_csb),
        .sram_web   (sram_web),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout)
    );

    // SRAM model: no reset (seeded with garbage), captures port at the edge,
    // write lands at the following edge, read data combinational from captured address.
    logic [WORD_WIDTH-1:0] mem [32];
    logic                  cap_csb = 1'b1;
    logic                  cap_web = 1'b1;
    logic [SET_BITS-1:0]   cap_addr = '0;
    logic [WORD_WIDTH-1:0] cap_din = '0;
    bit                    seeded = 1'b0;

    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 32; i++) mem[i] <= WORD_WIDTH'($urandom);
            seeded <= 1'b1;
        end else if (!cap_csb && !cap_web) begin
            mem[cap_addr] <= cap_din;
        end
        cap_csb  <= sram_csb;
        cap_web  <= sram_web;
        cap_addr <= sram_addr;
        cap_din  <= sram_din;
    end

    assign sram_dout = mem[cap_addr];

    task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, obs, exp);
        end
    endtask

    // Reference tag store and response scoreboard, sampled mid-cycle.
    logic [WORD_WIDTH-1:0] ref_mem [32];
    logic [WORD_WIDTH-1:0] sb_q [$];
    logic [WORD_WIDTH-1:0] w, e;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        end else begin
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    check_eq("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("rsp_hit", 32'(rsp_hit), 32'(e[22]));
                    check_eq("rsp_dirty", 32'(rsp_dirty), 32'(e[21]));
                    check_eq("rsp_tag", 32'(rsp_tag), 32'(e[20:0]));
                end
            end
            if (lk_valid && lk_ready) begin
                w = ref_mem[lk_set];
                sb_q.push_back({w[22] && (w[20:0] == lk_tag), w[22] && w[21], w[20:0]});
            end
            if (upd_valid && upd_ready) ref_mem[upd_set] = upd_word;
            if (flush_req) begin
                for (int i = 0; i < 32; i++) ref_mem[i] = '0;
            end
        end
    end

    task automatic check_reset_outs();
        check_eq("rst_csb", 32'(sram_csb), 32'd1);
        check_eq("rst_web", 32'(sram_web), 32'd1);
        check_eq("rst_addr", 32'(sram_addr), 32'd0);
        check_eq("rst_din", 32'(sram_din), 32'd0);
        check_eq("rst_init_done", 32'(init_done), 32'd0);
        check_eq("rst_lk_ready", 32'(lk_ready), 32'd0);
        check_eq("rst_upd_ready", 32'(upd_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_flush_done", 32'(flush_done), 32'd0);
        check_eq("rst_rsp_hit", 32'(rsp_hit), 32'd0);
        check_eq("rst_rsp_dirty", 32'(rsp_dirty), 32'd0);
        check_eq("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    endtask

    // Hold reset, check reset outputs, release, check the idle RST cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        lk_valid = 1'b1;
        upd_valid = 1'b1;
        flush_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outs();
        lk_valid = 1'b0;
        upd_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_first_csb", 32'(sram_csb), 32'd1);
    endtask

    // Expect 32 zero writes to sets 0..31; stop early after set stop_at.
    task automatic check_sweep(input bit flush, input int stop_at);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check_eq("sw_csb", 32'(sram_csb), 32'd0);
            check_eq("sw_web", 32'(sram_web), 32'd0);
            check_eq("sw_addr", 32'(sram_addr), 32'(i));
            check_eq("sw_din", 32'(sram_din), 32'd0);
            check_eq("sw_lk_ready", 32'(lk_ready), 32'd0);
            check_eq("sw_upd_ready", 32'(upd_ready), 32'd0);
            if (i == stop_at) return;
        end
        @(negedge clk);
        check_eq("sw_init_done", 32'(init_done), 32'd1);
        check_eq("sw_flush_done", 32'(flush_done), 32'(flush));
    endtask

    task automatic lookup(input logic [SET_BITS-1:0] s, input logic [TAG_WIDTH-1:0] t);
        logic acc;
        acc = 1'b0;
        lk_valid = 1'b1;
        lk_set = s;
        lk_tag = t;
        for (int n = 0; n < 64 && !acc; n++) begin
            @(negedge clk);
            acc = lk_ready;
            @(posedge clk);
            #1;
        end
        check_eq("lk_accept", 32'(acc), 32'd1);
        lk_valid = 1'b0;
    endtask

    task automatic update(input logic [SET_BITS-1:0] s, input logic [WORD_WIDTH-1:0] d);
        logic acc;
        acc = 1'b0;
        upd_valid = 1'b1;
        upd_set = s;
        upd_word = d;
        for (int n = 0; n < 64 && !acc; n++) begin
            @(negedge clk);
            acc = upd_ready;
            @(posedge clk);
            #1;
        end
        check_eq("upd_accept", 32'(acc), 32'd1);
        upd_valid = 1'b0;
    endtask

    initial begin
        // Post-reset clear, then every set must read back as invalid/zero.
        do_reset();
        check_sweep(1'b0, -1);
        @(posedge clk);
        #1;
        for (int s = 0; s < 32; s++) lookup(SET_BITS'(s), '0);

        // Miss, then write-then-read hazard in consecutive cycles.
        lookup(5'd5, 21'h1ABCD);
        update(5'd5, {1'b1, 1'b1, 21'h1ABCD});
        lookup(5'd5, 21'h1ABCD);

        // Update wins over a simultaneous lookup; then back-to-back lookups.
        upd_valid = 1'b1;
        upd_set = 5'd7;
        upd_word = {1'b1, 1'b0, 21'h00777};
        lk_valid = 1'b1;
        lk_set = 5'd7;
        lk_tag = 21'h00777;
        @(negedge clk);
        check_eq("arb_upd_ready", 32'(upd_ready), 32'd1);
        check_eq("arb_lk_ready", 32'(lk_ready), 32'd0);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        @(negedge clk);
        check_eq("arb_lk_next", 32'(lk_ready), 32'd1);
        @(posedge clk);
        #1;
        for (int k = 1; k <= 3; k++) begin
            lk_set = SET_BITS'(k);
            lk_tag = '0;
            @(negedge clk);
            check_eq("b2b_lk_ready", 32'(lk_ready), 32'd1);
            check_eq("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        lk_valid = 1'b0;
        @(negedge clk);
        check_eq("b2b_rsp_last", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("b2b_rsp_idle", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;

        // Fill sets 0..3, then flush with a competing lookup held off.
        for (int s = 0; s < 4; s++) update(SET_BITS'(s), {1'b1, 1'b0, 21'(s + 16)});
        lookup(5'd2, 21'd18);
        flush_req = 1'b1;
        lk_valid = 1'b1;
        lk_set = 5'd2;
        lk_tag = 21'd18;
        @(negedge clk);
        check_eq("fl_lk_ready", 32'(lk_ready), 32'd0);
        check_eq("fl_upd_ready", 32'(upd_ready), 32'd0);
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        check_sweep(1'b1, -1);
        @(posedge clk);
        #1;
        lk_valid = 1'b0;
        @(negedge clk);
        check_eq("fl_done_pulse", 32'(flush_done), 32'd0);
        check_eq("fl_init_kept", 32'(init_done), 32'd1);
        check_eq("fl_rsp_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;

        // Reset in the middle of a sweep, then a full restart from set 0.
        do_reset();
        check_sweep(1'b0, 17);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outs();
        @(posedge clk);
        #1;
        do_reset();
        check_sweep(1'b0, -1);
        @(posedge clk);
        #1;
        lookup(5'd5, 21'h1ABCD);
        repeat (2) @(posedge clk);
        #1;
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mp_cache_tag_ctrl.md
Name: mp_cache_tag_ctrl

Overview:
- Sequencing controller for the 32-entry x 23-bit single-port tag SRAM macro used by the cache.
- Clears the SRAM after reset, since the macro has no reset.
- Arbitrates the single RW port between three sources: flush sweep, tag update writes from the cache FSM, and tag lookups.
- Returns hit/dirty/victim information one cycle after each lookup is accepted.

Parameters:
- SET_BITS, 5, SRAM address width (32 sets)
- TAG_WIDTH, 21, stored tag width
- WORD_WIDTH, 23, SRAM word = {valid[22], dirty[21], tag[20:0]}

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- init_done  output  1  high once the post-reset clear sweep is complete
- lk_valid  input  1  lookup request
- lk_ready  output  1  lookup accepted when lk_valid & lk_ready
- lk_set  input  SET_BITS  lookup set index
- lk_tag  input  TAG_WIDTH  lookup tag
- rsp_valid  output  1  one-cycle pulse, lookup result valid
- rsp_hit  output  1  valid & stored tag == requested tag
- rsp_dirty  output  1  valid & dirty of the stored entry
- rsp_tag  output  TAG_WIDTH  stored (victim) tag
- upd_valid  input  1  tag write request
- upd_ready  output  1  write accepted when upd_valid & upd_ready
- upd_set  input  SET_BITS  write set index
- upd_word  input  WORD_WIDTH  word to write
- flush_req  input  1  level request: invalidate all sets
- flush_done  output  1  one-cycle pulse, flush complete
- sram_csb  output  1  SRAM chip select, active low
- sram_web  output  1  SRAM write enable, active low
- sram_addr  output  SET_BITS  SRAM address
- sram_din  output  WORD_WIDTH  SRAM write data
- sram_dout  input  WORD_WIDTH  SRAM read data; valid the cycle after a read is issued

Behaviour:
- The SRAM captures csb/web/addr/din at a clock edge. A write lands at the next edge. Read data is combinational from the captured address.
- Hazard rule: a write issued in cycle N followed by a read of the same set in cycle N+1 returns the new data. No forwarding logic is required.
- States: RST, SWEEP, IDLE.
- Reset values (rst_n low): state=RST, sweep_cnt=0, pend=0.
  - Outputs during reset: sram_csb=1, sram_web=1, sram_addr=0, sram_din=0.
  - Outputs during reset: init_done=0, lk_ready=0, upd_ready=0, rsp_valid=0, flush_done=0.
  - Outputs during reset: rsp_hit/rsp_dirty=0, rsp_tag=0.
- RST -> SWEEP on the first clock after reset deassertion. Set is_flush=0.
- SWEEP:
  - Each cycle drives csb=0, web=0, addr=sweep_cnt, din=0.
  - sweep_cnt increments each cycle.
  - After the write to set 31 is issued: go to IDLE and reset sweep_cnt to 0.
  - On that transition, set init_done=1 if is_flush=0; otherwise pulse flush_done for one cycle.
  - lk_ready=upd_ready=0 throughout. Lookup/update requests are held off, not dropped.
- IDLE priority: flush_req > upd_valid > lk_valid.
  - flush_req=1: go to SWEEP with is_flush=1. No lookup or update is accepted that cycle.
  - upd_ready = !flush_req. On accept: csb=0, web=0, addr=upd_set, din=upd_word. Single cycle.
  - lk_ready = !flush_req & !upd_valid. On accept: csb=0, web=1, addr=lk_set. Register lk_tag into tag_q and set pend=1.
  - Nothing accepted: csb=1.
- Response:
  - pend=1 produces rsp_valid=1 in the following cycle.
  - rsp_hit = sram_dout[22] & (sram_dout[20:0]==tag_q).
  - rsp_dirty = sram_dout[22] & sram_dout[21].
  - rsp_tag = sram_dout[20:0].
  - rsp_hit/rsp_dirty are 0 when rsp_valid=0.
  - There is no response back-pressure. The consumer must sample rsp_valid.
- Throughput:
  - One lookup per cycle. A new lookup may be accepted in the same cycle a response is presented.
  - An update may follow a lookup back-to-back.
- A pend left set when flush is entered still produces its response in the first SWEEP cycle.
- flush_req asserted during the initial sweep is serviced after init_done rises.
- Asynchronous reset mid-sweep or mid-lookup: any pending response is discarded, and the sequence restarts from RST and a full sweep from set 0.

Decomposition:
- Package mp_cache_tag_pkg contains:
  - SET_BITS, TAG_WIDTH, WORD_WIDTH constants
  - packed struct tag_word_t {valid, dirty, tag}
  - enum ctrl_state_t {RST, SWEEP, IDLE}
- One sub-module, mp_cache_tag_sweep: a 5-bit sweep counter with start/last/done, shared by the init and flush paths.

Test Plan:
- Reset release -> first cycle csb=1. Then 32 consecutive writes, addr 0..31, din=0. init_done=1 after the set-31 write is issued, then every set reads 0.
- After init, lookup set 5 tag 0x1ABCD -> rsp_valid next cycle with hit=0, dirty=0, tag=0.
- Update set 5 with {1,1,0x1ABCD}, then lookup set 5 tag 0x1ABCD in the very next cycle -> hit=1, dirty=1, tag=0x1ABCD.
- upd_valid and lk_valid in the same IDLE cycle -> upd_ready=1, lk_ready=0. Lookup accepted next cycle. Back-to-back lookups to sets 1,2,3 -> three consecutive rsp_valid pulses.
- Fill sets 0..3 valid, then assert flush_req together with lk_valid -> lookup not accepted. 32 zero writes, then a flush_done pulse, init_done stays 1, lookup of set 2 misses.
- Drop rst_n at sweep_cnt=17 -> outputs return to reset values immediately. After release, the sweep restarts at addr 0 and runs all 32 writes.
